// File: rtl/cp0_regfile.sv
// Coprocessor-0 register file: Status/Cause/EPC/BadVAddr/EntryHi/Count/
// Compare/PRId/EBase, exception-entry and ERET updates, and the Count/Compare
// timer that feeds the hardware interrupt line IP[7].
module cp0_regfile #(
   parameter logic [31:0] PRID_VALUE  = 32'h0001_8000,
   parameter logic [31:0] EBASE_RESET = 32'h8000_0000,
   parameter logic        COUNT_DIV2  = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        we,
   input  logic [4:0]  waddr,
   input  logic [2:0]  wsel,
   input  logic [31:0] wdata,
   input  logic [4:0]  raddr,
   input  logic [2:0]  rsel,
   output logic [31:0] rdata,
   input  logic [5:0]  hw_int_in,
   input  logic        in_exp,
   input  logic        clean_exl,
   input  logic [4:0]  exp_code,
   input  logic [31:0] exp_epc,
   input  logic        exp_bd,
   input  logic        badv_we,
   input  logic [31:0] exp_bad_vaddr,
   input  logic        exp_asid_we,
   input  logic [7:0]  exp_asid,
   output logic        allow_int,
   output logic [7:0]  interrupt_mask,
   output logic [5:0]  hardware_int,
   output logic [1:0]  software_int,
   output logic        special_int_vec,
   output logic        boot_exp_vec,
   output logic        exl,
   output logic [19:0] ebase_out,
   output logic [31:0] epc_out,
   output logic [7:0]  asid_out,
   output logic        timer_int
);

   // Status fields
   logic        cu0_q, cu0_d, bev_q, bev_d, um_q, um_d, exl_q, exl_d, ie_q, ie_d;
   logic [7:0]  im_q, im_d;
   // Cause fields
   logic        bd_q, bd_d, ti_q, ti_d, iv_q, iv_d;
   logic [7:0]  ip_q, ip_d;
   logic [4:0]  exccode_q, exccode_d;
   // Address / timer registers
   logic [31:0] epc_q, epc_d, badvaddr_q, badvaddr_d;
   logic [18:0] vpn2_q, vpn2_d;
   logic [7:0]  asid_q, asid_d;
   logic [31:0] count_q, count_d, compare_q, compare_d;
   logic [17:0] ebase_q, ebase_d;
   logic        div_q, div_d;

   logic        wr_status, wr_cause, wr_epc, wr_entryhi, wr_count, wr_compare, wr_ebase;
   logic        tick;
   logic [31:0] count_inc;

   assign wr_status  = we && (waddr == 5'd12) && (wsel == 3'd0);
   assign wr_cause   = we && (waddr == 5'd13) && (wsel == 3'd0);
   assign wr_epc     = we && (waddr == 5'd14) && (wsel == 3'd0);
   assign wr_entryhi = we && (waddr == 5'd10) && (wsel == 3'd0);
   assign wr_count   = we && (waddr == 5'd9)  && (wsel == 3'd0);
   assign wr_compare = we && (waddr == 5'd11) && (wsel == 3'd0);
   assign wr_ebase   = we && (waddr == 5'd15) && (wsel == 3'd1);

   // In divide-by-2 mode Count advances on the cycles where the phase bit is set.
   assign tick      = COUNT_DIV2 ? div_q : 1'b1;
   assign count_inc = count_q + 32'd1;

   // Next-state logic; per field, exception entry beats ERET beats MTC0 beats timer.
   always_comb begin
      cu0_d      = cu0_q;
      bev_d      = bev_q;
      im_d       = im_q;
      um_d       = um_q;
      exl_d      = exl_q;
      ie_d       = ie_q;
      bd_d       = bd_q;
      ti_d       = ti_q;
      iv_d       = iv_q;
      exccode_d  = exccode_q;
      epc_d      = epc_q;
      badvaddr_d = badvaddr_q;
      vpn2_d     = vpn2_q;
      asid_d     = asid_q;
      compare_d  = compare_q;
      ebase_d    = ebase_q;
      count_d    = count_q;
      div_d      = COUNT_DIV2 ? ~div_q : 1'b0;
      // IP[7:2] samples the external lines every cycle; IP[7] also carries the timer.
      ip_d       = {hw_int_in[5] | ti_q, hw_int_in[4:0], ip_q[1:0]};

      if (wr_status) begin
         cu0_d = wdata[28];
         bev_d = wdata[22];
         im_d  = wdata[15:8];
         um_d  = wdata[4];
         ie_d  = wdata[0];
      end
      if (in_exp) begin
         exl_d = 1'b1;
      end else if (clean_exl) begin
         exl_d = 1'b0;
      end else if (wr_status) begin
         exl_d = wdata[1];
      end

      if (wr_cause) begin
         iv_d       = wdata[23];
         ip_d[1:0]  = wdata[9:8];
      end

      // A nested entry (EXL already set) keeps the original EPC and BD.
      if (in_exp) begin
         exccode_d = exp_code;
         if (!exl_q) begin
            epc_d = exp_epc;
            bd_d  = exp_bd;
         end
      end else if (wr_epc) begin
         epc_d = wdata;
      end

      if (badv_we) begin
         badvaddr_d = exp_bad_vaddr;
      end

      if (exp_asid_we) begin
         vpn2_d = exp_bad_vaddr[31:13];
         asid_d = exp_asid;
      end else if (wr_entryhi) begin
         vpn2_d = wdata[31:13];
         asid_d = wdata[7:0];
      end

      if (wr_ebase) begin
         ebase_d = wdata[29:12];
      end

      if (wr_compare) begin
         compare_d = wdata;
      end

      if (wr_count) begin
         count_d = wdata;
      end else if (tick) begin
         count_d = count_inc;
      end

      // Only an increment reaching Compare raises TI; a Compare write always clears it.
      if (wr_compare) begin
         ti_d = 1'b0;
      end else if (tick && !wr_count && (count_inc == compare_q)) begin
         ti_d = 1'b1;
      end
   end

   // State registers with asynchronous reset to architectural reset values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cu0_q      <= 1'b0;
         bev_q      <= 1'b1;
         im_q       <= 8'h00;
         um_q       <= 1'b0;
         exl_q      <= 1'b0;
         ie_q       <= 1'b0;
         bd_q       <= 1'b0;
         ti_q       <= 1'b0;
         iv_q       <= 1'b0;
         ip_q       <= 8'h00;
         exccode_q  <= 5'd0;
         epc_q      <= 32'd0;
         badvaddr_q <= 32'd0;
         vpn2_q     <= 19'd0;
         asid_q     <= 8'd0;
         count_q    <= 32'd0;
         compare_q  <= 32'd0;
         ebase_q    <= EBASE_RESET[29:12];
         div_q      <= 1'b0;
      end else begin
         cu0_q      <= cu0_d;
         bev_q      <= bev_d;
         im_q       <= im_d;
         um_q       <= um_d;
         exl_q      <= exl_d;
         ie_q       <= ie_d;
         bd_q       <= bd_d;
         ti_q       <= ti_d;
         iv_q       <= iv_d;
         ip_q       <= ip_d;
         exccode_q  <= exccode_d;
         epc_q      <= epc_d;
         badvaddr_q <= badvaddr_d;
         vpn2_q     <= vpn2_d;
         asid_q     <= asid_d;
         count_q    <= count_d;
         compare_q  <= compare_d;
         ebase_q    <= ebase_d;
         div_q      <= div_d;
      end
   end

   // MFC0 read mux from registered state; unimplemented reg/sel reads zero.
   always_comb begin
      rdata = 32'd0;
      case ({raddr, rsel})
         {5'd8,  3'd0}: rdata = badvaddr_q;
         {5'd9,  3'd0}: rdata = count_q;
         {5'd10, 3'd0}: rdata = {vpn2_q, 5'd0, asid_q};
         {5'd11, 3'd0}: rdata = compare_q;
         {5'd12, 3'd0}: rdata = {3'd0, cu0_q, 5'd0, bev_q, 6'd0, im_q, 3'd0, um_q, 2'd0, exl_q, ie_q};
         {5'd13, 3'd0}: rdata = {bd_q, ti_q, 6'd0, iv_q, 7'd0, ip_q, 1'b0, exccode_q, 2'd0};
         {5'd14, 3'd0}: rdata = epc_q;
         {5'd15, 3'd0}: rdata = PRID_VALUE;
         {5'd15, 3'd1}: rdata = {2'b10, ebase_q, 12'd0};
         default:       rdata = 32'd0;
      endcase
   end

   assign allow_int       = ie_q & ~exl_q;
   assign interrupt_mask  = im_q;
   assign hardware_int    = ip_q[7:2];
   assign software_int    = ip_q[1:0];
   assign special_int_vec = iv_q;
   assign boot_exp_vec    = bev_q;
   assign exl             = exl_q;
   assign ebase_out       = {2'b10, ebase_q};
   assign epc_out         = epc_q;
   assign asid_out        = asid_q;
   assign timer_int       = ti_q;

endmodule

// File: tb/tb_cp0_regfile.sv
// Bench for cp0_regfile: expectations are queued as stimulus is applied and
// compared against the DUT outputs on the falling clock edge.
module tb_cp0_regfile;

   localparam logic [31:0] PRID = 32'h0001_8000;

   localparam int K_RD    = 0;
   localparam int K_AINT  = 1;
   localparam int K_BEV   = 2;
   localparam int K_EXL   = 3;
   localparam int K_EBASE = 4;
   localparam int K_EPC   = 5;
   localparam int K_ASID  = 6;
   localparam int K_TI    = 7;
   localparam int K_HWI   = 8;
   localparam int K_RD2   = 9;
   localparam int K_IM    = 10;
   localparam int K_SWI   = 11;
   localparam int K_IV    = 12;

   logic        clk, rst_n, we, in_exp, clean_exl, exp_bd, badv_we, exp_asid_we;
   logic [4:0]  waddr, raddr, exp_code;
   logic [2:0]  wsel, rsel;
   logic [31:0] wdata, exp_epc, exp_bad_vaddr;
   logic [5:0]  hw_int_in;
   logic [7:0]  exp_asid;

   logic [31:0] rdata, epc_out;
   logic        allow_int, special_int_vec, boot_exp_vec, exl, timer_int;
   logic [7:0]  interrupt_mask, asid_out;
   logic [5:0]  hardware_int;
   logic [1:0]  software_int;
   logic [19:0] ebase_out;

   logic [31:0] rdata2, epc_out2;
   logic        allow_int2, special_int_vec2, boot_exp_vec2, exl2, timer_int2;
   logic [7:0]  interrupt_mask2, asid_out2;
   logic [5:0]  hardware_int2;
   logic [1:0]  software_int2;
   logic [19:0] ebase_out2;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      string       tag;
      int          kind;
      logic [31:0] exp;
   } sb_t;
   sb_t sb[$];

   cp0_regfile #(.PRID_VALUE(PRID), .EBASE_RESET(32'h8000_0000), .COUNT_DIV2(1'b0)) dut (
      .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wsel(wsel), .wdata(wdata),
      .raddr(raddr), .rsel(rsel), .rdata(rdata), .hw_int_in(hw_int_in),
      .in_exp(in_exp), .clean_exl(clean_exl), .exp_code(exp_code), .exp_epc(exp_epc),
      .exp_bd(exp_bd), .badv_we(badv_we), .exp_bad_vaddr(exp_bad_vaddr),
      .exp_asid_we(exp_asid_we), .exp_asid(exp_asid), .allow_int(allow_int),
      .interrupt_mask(interrupt_mask), .hardware_int(hardware_int),
      .software_int(software_int), .special_int_vec(special_int_vec),
      .boot_exp_vec(boot_exp_vec), .exl(exl), .ebase_out(ebase_out),
      .epc_out(epc_out), .asid_out(asid_out), .timer_int(timer_int));

   // Second instance exercises the divide-by-2 Count rate.
   cp0_regfile #(.PRID_VALUE(PRID), .EBASE_RESET(32'h8000_0000), .COUNT_DIV2(1'b1)) dut2 (
      .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wsel(wsel), .wdata(wdata),
      .raddr(raddr), .rsel(rsel), .rdata(rdata2), .hw_int_in(hw_int_in),
      .in_exp(in_exp), .clean_exl(clean_exl), .exp_code(exp_code), .exp_epc(exp_epc),
      .exp_bd(exp_bd), .badv_we(badv_we), .exp_bad_vaddr(exp_bad_vaddr),
      .exp_asid_we(exp_asid_we), .exp_asid(exp_asid), .allow_int(allow_int2),
      .interrupt_mask(interrupt_mask2), .hardware_int(hardware_int2),
      .software_int(software_int2), .special_int_vec(special_int_vec2),
      .boot_exp_vec(boot_exp_vec2), .exl(exl2), .ebase_out(ebase_out2),
      .epc_out(epc_out2), .asid_out(asid_out2), .timer_int(timer_int2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, want);
      end
   endtask

   function automatic logic [31:0] obs(input int k);
      case (k)
         K_RD:    return rdata;
         K_AINT:  return {31'd0, allow_int};
         K_BEV:   return {31'd0, boot_exp_vec};
         K_EXL:   return {31'd0, exl};
         K_EBASE: return {12'd0, ebase_out};
         K_EPC:   return epc_out;
         K_ASID:  return {24'd0, asid_out};
         K_TI:    return {31'd0, timer_int};
         K_HWI:   return {26'd0, hardware_int};
         K_RD2:   return rdata2;
         K_IM:    return {24'd0, interrupt_mask};
         K_SWI:   return {30'd0, software_int};
         K_IV:    return {31'd0, special_int_vec};
         default: return 32'hDEAD_BEEF;
      endcase
   endfunction

   // Scoreboard drain: every queued expectation is compared on the falling edge.
   always @(negedge clk) begin : mon
      sb_t e;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         check(e.tag, obs(e.kind), e.exp);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
      #1;
   endtask

   task automatic want(input string tag, input int k, input logic [31:0] v);
      sb_t e;
      e.tag  = tag;
      e.kind = k;
      e.exp  = v;
      sb.push_back(e);
   endtask

   task automatic rd(input string tag, input logic [4:0] a, input logic [2:0] s,
                     input logic [31:0] v);
      raddr = a;
      rsel  = s;
      want(tag, K_RD, v);
      sample();
   endtask

   task automatic mtc0(input logic [4:0] a, input logic [2:0] s, input logic [31:0] d);
      we = 1'b1; waddr = a; wsel = s; wdata = d;
      step();
      we = 1'b0;
   endtask

   task automatic exc(input logic [4:0] code, input logic [31:0] epc, input logic bd);
      in_exp = 1'b1; exp_code = code; exp_epc = epc; exp_bd = bd;
      step();
      in_exp = 1'b0; exp_bd = 1'b0; badv_we = 1'b0; exp_asid_we = 1'b0;
   endtask

   task automatic eret();
      clean_exl = 1'b1;
      step();
      clean_exl = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; we = 1'b0; waddr = '0; wsel = '0; wdata = '0;
      raddr = '0; rsel = '0; hw_int_in = '0; in_exp = 1'b0; clean_exl = 1'b0;
      exp_code = '0; exp_epc = '0; exp_bd = 1'b0; badv_we = 1'b0;
      exp_bad_vaddr = '0; exp_asid_we = 1'b0; exp_asid = '0;

      // Reset state
      repeat (2) sample();
      want("rst_allow_int", K_AINT, 32'd0);
      want("rst_bev", K_BEV, 32'd1);
      want("rst_ebase_out", K_EBASE, 32'h0008_0000);
      want("rst_timer", K_TI, 32'd0);
      rd("rst_status", 5'd12, 3'd0, 32'h0040_0000);
      rd("rst_ebase", 5'd15, 3'd1, 32'h8000_0000);
      rd("rst_prid", 5'd15, 3'd0, PRID);
      rst_n = 1'b1;
      step();

      // Status write then exception entry
      mtc0(5'd12, 3'd0, 32'h0000_FF01);
      want("st_allow_int", K_AINT, 32'd1);
      want("st_im", K_IM, 32'h0000_00FF);
      want("st_bev", K_BEV, 32'd0);
      rd("st_status", 5'd12, 3'd0, 32'h0000_FF01);
      exc(5'h0C, 32'h8000_1004, 1'b1);
      want("exc_exl", K_EXL, 32'd1);
      want("exc_allow_int", K_AINT, 32'd0);
      want("exc_epc_out", K_EPC, 32'h8000_1004);
      rd("exc_cause", 5'd13, 3'd0, 32'h8000_0030);

      // Nested entry keeps EPC and BD, updates ExcCode
      exc(5'h04, 32'h8000_2000, 1'b0);
      want("nest_exl", K_EXL, 32'd1);
      rd("nest_epc", 5'd14, 3'd0, 32'h8000_1004);
      rd("nest_cause", 5'd13, 3'd0, 32'h8000_0010);
      eret();
      want("eret_exl", K_EXL, 32'd0);
      want("eret_allow_int", K_AINT, 32'd1);
      rd("eret_status", 5'd12, 3'd0, 32'h0000_FF01);

      // TLB-style entry updating BadVAddr and EntryHi
      badv_we = 1'b1; exp_asid_we = 1'b1;
      exp_bad_vaddr = 32'h0040_3123; exp_asid = 8'h5A;
      exc(5'h02, 32'h8000_3000, 1'b0);
      want("tlb_asid_out", K_ASID, 32'h0000_005A);
      rd("tlb_badv", 5'd8, 3'd0, 32'h0040_3123);
      rd("tlb_entryhi", 5'd10, 3'd0, 32'h0040_205A);
      rd("tlb_cause", 5'd13, 3'd0, 32'h0000_0008);
      mtc0(5'd8, 3'd0, 32'h0000_0000);
      rd("badv_ro", 5'd8, 3'd0, 32'h0040_3123);
      eret();

      // Exception entry beats a same-cycle MTC0 to EPC
      we = 1'b1; waddr = 5'd14; wsel = 3'd0; wdata = 32'h0000_1234;
      exc(5'h00, 32'h8000_4000, 1'b0);
      we = 1'b0;
      rd("same_epc", 5'd14, 3'd0, 32'h8000_4000);
      eret();

      // Hardware and software interrupt bits in Cause
      hw_int_in = 6'b010101;
      step();
      want("hw_int", K_HWI, 32'h0000_0015);
      rd("hw_cause", 5'd13, 3'd0, 32'h0000_5400);
      mtc0(5'd13, 3'd0, 32'hFFFF_FFFF);
      want("sw_int", K_SWI, 32'd3);
      want("iv", K_IV, 32'd1);
      rd("cause_wr", 5'd13, 3'd0, 32'h0080_5700);
      hw_int_in = 6'b000000;
      mtc0(5'd13, 3'd0, 32'h0000_0000);
      rd("cause_clr", 5'd13, 3'd0, 32'h0000_0000);

      // EBase, read-only PRId, unimplemented register
      mtc0(5'd15, 3'd1, 32'hFFFF_FFFF);
      want("ebase_out_wr", K_EBASE, 32'h000B_FFFF);
      rd("ebase_wr", 5'd15, 3'd1, 32'hBFFF_F000);
      mtc0(5'd15, 3'd0, 32'h0000_0000);
      rd("prid_ro", 5'd15, 3'd0, PRID);
      mtc0(5'd16, 3'd0, 32'hFFFF_FFFF);
      rd("unimpl", 5'd16, 3'd0, 32'h0000_0000);

      // Count/Compare timer
      mtc0(5'd11, 3'd0, 32'd10);
      mtc0(5'd9, 3'd0, 32'd5);
      want("tmr_ti0", K_TI, 32'd0);
      rd("tmr_cnt5", 5'd9, 3'd0, 32'd5);
      repeat (4) step();
      want("tmr_ti_pre", K_TI, 32'd0);
      rd("tmr_cnt9", 5'd9, 3'd0, 32'd9);
      step();
      want("tmr_ti_set", K_TI, 32'd1);
      want("tmr_hwi_lag", K_HWI, 32'd0);
      rd("tmr_cnt10", 5'd9, 3'd0, 32'd10);
      step();
      want("tmr_ti_sticky", K_TI, 32'd1);
      want("tmr_hwi5", K_HWI, 32'h0000_0020);
      rd("tmr_cause", 5'd13, 3'd0, 32'h4000_8000);
      mtc0(5'd11, 3'd0, 32'd100);
      want("cmp_clear", K_TI, 32'd0);
      sample();
      mtc0(5'd9, 3'd0, 32'd100);
      want("cnt_eq_wr_ti", K_TI, 32'd0);
      rd("cnt_wr100", 5'd9, 3'd0, 32'd100);
      step();
      want("cnt_eq_after", K_TI, 32'd0);
      sample();

      // Compare write on the same edge an increment would raise TI
      mtc0(5'd11, 3'd0, 32'd200);
      mtc0(5'd9, 3'd0, 32'd198);
      step();
      mtc0(5'd11, 3'd0, 32'd500);
      want("clear_wins_ti", K_TI, 32'd0);
      rd("clear_wins_cnt", 5'd9, 3'd0, 32'd200);

      // Count wrap
      mtc0(5'd9, 3'd0, 32'hFFFF_FFFF);
      rd("wrap_pre", 5'd9, 3'd0, 32'hFFFF_FFFF);
      step();
      want("wrap_ti", K_TI, 32'd0);
      rd("wrap_zero", 5'd9, 3'd0, 32'd0);

      // Asynchronous reset mid-count
      rst_n = 1'b0;
      raddr = 5'd9; rsel = 3'd0;
      want("arst_cnt", K_RD, 32'd0);
      want("arst_cnt2", K_RD2, 32'd0);
      want("arst_ti", K_TI, 32'd0);
      sample();
      want("arst_bev", K_BEV, 32'd1);
      want("arst_ebase_out", K_EBASE, 32'h0008_0000);
      rd("arst_status", 5'd12, 3'd0, 32'h0040_0000);
      rst_n = 1'b1;
      repeat (6) step();
      raddr = 5'd9; rsel = 3'd0;
      want("cnt_div1", K_RD, 32'd6);
      want("cnt_div2", K_RD2, 32'd3);
      sample();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/cp0_regfile.md
Name: cp0_regfile

Overview:
- Coprocessor-0 register file, directly downstream of the exception detector/handler.
- Consumes its exception-entry outputs (in_exp, exp_code, exp_epc, BadVAddr/ASID writes) and its ERET output (clean_exl).
- Serves MFC0/MTC0 from the pipeline.
- Produces the status/vector/interrupt signals the exception unit evaluates each cycle; also owns the Count/Compare timer.

Parameters:
- PRID_VALUE, 32'h0001_8000, read-only value of PRId (reg 15 sel 0).
- EBASE_RESET, 32'h8000_0000, reset value of EBase (reg 15 sel 1).
- COUNT_DIV2, 1'b1, 1 = Count increments every second clk; 0 = every clk.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- we  in  1  MTC0 write strobe.
- waddr  in  5  MTC0 register number.
- wsel  in  3  MTC0 select.
- wdata  in  32  MTC0 data.
- raddr  in  5  MFC0 register number.
- rsel  in  3  MFC0 select.
- rdata  out  32  MFC0 data, combinational from current state.
- hw_int_in  in  6  external interrupt lines, level, already synchronised.
- in_exp  in  1  exception entry this cycle.
- clean_exl  in  1  ERET this cycle.
- exp_code  in  5  ExcCode for entry.
- exp_epc  in  32  return address (delay-slot adjusted).
- exp_bd  in  1  faulting instruction in delay slot.
- badv_we  in  1  write BadVAddr.
- exp_bad_vaddr  in  32  BadVAddr value.
- exp_asid_we  in  1  TLB exception, update EntryHi.
- exp_asid  in  8  ASID for EntryHi.
- allow_int  out  1  Status.IE & ~Status.EXL.
- interrupt_mask  out  8  Status.IM[7:0].
- hardware_int  out  6  Cause.IP[7:2].
- software_int  out  2  Cause.IP[1:0].
- special_int_vec  out  1  Cause.IV.
- boot_exp_vec  out  1  Status.BEV.
- exl  out  1  Status.EXL.
- ebase_out  out  20  EBase[31:12].
- epc_out  out  32  EPC.
- asid_out  out  8  EntryHi.ASID.
- timer_int  out  1  Cause.TI.

Behaviour:
Registers implemented:
- BadVAddr(8,0): read-only to MTC0.
- Count(9,0)
- EntryHi(10,0): VPN2[31:13] and ASID[7:0] writable, other bits 0.
- Compare(11,0)
- Status(12,0): writable bits are CU0[28], BEV[22], IM[15:8], UM[4], EXL[1], IE[0]; others read 0.
- Cause(13,0): BD[31], TI[30], IV[23], IP[15:8], ExcCode[6:2]. Only IV and IP[1:0] are MTC0-writable.
- EPC(14,0)
- PRId(15,0): read-only.
- EBase(15,1): bits[29:12] writable; [31:30] read as 2'b10; [11:0] read 0.
- Unimplemented reg/sel: reads 0, writes ignored.

Reset values:
- Status = 32'h0040_0000 (BEV=1).
- Cause, EPC, BadVAddr, EntryHi, Count, Compare = 0; EBase = EBASE_RESET; divider phase = 0.
- Outputs follow state: allow_int=0, boot_exp_vec=1, ebase_out=20'h80000, timer_int=0.

Write timing and priority:
- All updates take effect at the next rising edge; rdata and outputs reflect registered state only, with no same-cycle bypass.
- Per-field priority, high to low: in_exp, then clean_exl, then MTC0, then timer/increment.

Exception entry (in_exp=1):
- Always: Status.EXL<=1, Cause.ExcCode<=exp_code.
- Only if EXL was 0: EPC<=exp_epc, Cause.BD<=exp_bd. If EXL was 1, EPC and BD are held.
- badv_we=1: BadVAddr<=exp_bad_vaddr.
- exp_asid_we=1: EntryHi.ASID<=exp_asid and EntryHi.VPN2<=exp_bad_vaddr[31:13].
- A simultaneous MTC0 to any touched field is dropped; an MTC0 to untouched fields proceeds.

ERET (clean_exl=1, in_exp=0):
- Status.EXL<=0; no other field changes.

Hardware interrupts:
- Cause.IP[7:2] <= {hw_int_in[5] | TI, hw_int_in[4:0]} every cycle; not MTC0-writable.

Count and timer:
- Increments when the divider ticks (every clk if COUNT_DIV2=0, else on alternate clks). Wraps 32'hFFFF_FFFF->0.
- MTC0 to Count overrides that cycle's increment.
- TI<=1 on the edge where an increment makes Count equal Compare. TI is sticky.
- MTC0 to Compare clears TI. An MTC0-written Count equal to Compare does not set TI.
- If a Compare write and a TI-set occur in the same cycle, the clear wins.

Reset mid-operation: asynchronous; all fields return to reset values immediately.

Test Plan:
- Reset then MFC0 12/0, 15/1, 15/0 -> 32'h0040_0000, 32'h8000_0000, PRID_VALUE; allow_int=0, boot_exp_vec=1.
- MTC0 Status=32'h0000_FF01, then in_exp with exp_code=5'h0C, exp_epc=32'h8000_1004, exp_bd=1 -> EPC=32'h8000_1004, Cause[6:2]=5'h0C, Cause.BD=1, exl=1, allow_int=0. Then clean_exl -> exl=0, allow_int=1.
- Nested entry while EXL=1 with exp_epc=32'h8000_2000 -> EPC unchanged at 32'h8000_1004; ExcCode is updated.
- TLB entry with badv_we=1, exp_asid_we=1, exp_bad_vaddr=32'h0040_3123, exp_asid=8'h5A -> BadVAddr=32'h0040_3123, EntryHi=32'h0040_205A, asid_out=8'h5A.
- COUNT_DIV2=0: MTC0 Compare=10, MTC0 Count=5 -> timer_int=1 after 5 increments, hardware_int[5]=1. MTC0 Compare=100 -> timer_int=0 next cycle. Count=32'hFFFF_FFFF wraps to 0.
- Same cycle: in_exp plus MTC0 EPC=32'h1234 with EXL=0 -> EPC=exp_epc. Assert rst_n low mid-count -> Count=0 immediately.
